// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encodings and the
// channel-select width derivation used by the top level and its bench.
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // A single channel still needs a 1-bit select so the port never collapses.
    function automatic int ch_sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, 2-sample history clocked by a
// shared sample tick, and a one-clock press pulse on a 0->1 sample transition.
module btn_debounce
    import pwm_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_press
);

    logic [1:0] r_sync;
    logic [1:0] r_hist;
    logic       r_tick_d;

    // Synchronise the raw button and shift a new sample in on every tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_hist   <= '0;
            r_tick_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_btn};
            r_tick_d <= i_tick;
            if (i_tick) begin
                r_hist <= {r_hist[0], r_sync[1]};
            end
        end
    end

    // History is only fresh in the clock after a tick, so a held button
    // yields exactly one pulse.
    assign o_press = r_tick_d & r_hist[0] & ~r_hist[1];

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: NUM_CH outputs share one period counter,
// per-channel duty set by debounced inc/dec buttons, edge- or center-aligned.
// Duty and mode changes are staged in shadow registers and taken at the
// period boundary so outputs never glitch.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DEB_DIV   = 2,
    parameter int DUTY_INIT = 5,
    localparam int CH_SEL_W = ch_sel_width(NUM_CH)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                inc_btn,
    input  logic                dec_btn,
    input  logic [CH_SEL_W-1:0] ch_sel,
    input  logic                mode,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic [CNT_W-1:0]    duty_o,
    output logic                period_wrap
);

    localparam int                TICK_W    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  DUTY_MAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  DUTY_RST  = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W:0]    STEP_X    = (CNT_W + 1)'(STEP);
    localparam logic [CH_SEL_W:0] NUM_CH_X  = (CH_SEL_W + 1)'(NUM_CH);

    logic [TICK_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dir_down;
    logic              r_mode_act;
    logic [CNT_W-1:0]  r_duty_sh  [NUM_CH];
    logic [CNT_W-1:0]  r_duty_act [NUM_CH];
    logic [NUM_CH-1:0] r_pwm_p1;
    logic              r_wrap_p1;

    logic w_tick;
    logic w_inc_press;
    logic w_dec_press;
    logic w_ch_ok;
    logic w_inc_ev;
    logic w_dec_ev;
    logic w_bnd;

    // Widened sum so the saturation test sees the true result.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} + STEP_X;
        return (s > {1'b0, DUTY_MAX}) ? DUTY_MAX : s[CNT_W-1:0];
    endfunction

    // A borrow into the extra bit means the step went below zero.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} - STEP_X;
        return s[CNT_W] ? '0 : s[CNT_W-1:0];
    endfunction

    // Debounce sample tick, frozen while the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (ena) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = ena && (r_tick_cnt == TICK_LAST);

    btn_debounce u_inc_deb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (w_tick),
        .i_btn   (inc_btn),
        .o_press (w_inc_press)
    );

    btn_debounce u_dec_deb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tick  (w_tick),
        .i_btn   (dec_btn),
        .o_press (w_dec_press)
    );

    // Conflicting inc+dec cancel; out-of-range selects are ignored.
    assign w_ch_ok  = ({1'b0, ch_sel} < NUM_CH_X);
    assign w_inc_ev = ena & w_ch_ok & w_inc_press & ~w_dec_press;
    assign w_dec_ev = ena & w_ch_ok & w_dec_press & ~w_inc_press;

    // Shadow duty registers, edited by button events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= DUTY_RST;
        end else if (w_inc_ev) begin
            r_duty_sh[ch_sel] <= sat_inc(r_duty_sh[ch_sel]);
        end else if (w_dec_ev) begin
            r_duty_sh[ch_sel] <= sat_dec(r_duty_sh[ch_sel]);
        end
    end

    assign duty_o = w_ch_ok ? r_duty_sh[ch_sel] : '0;

    // Edge mode wraps at the top; center mode wraps at the bottom of the down ramp.
    assign w_bnd = ena && ((r_mode_act == PWM_MODE_EDGE) ? (r_cnt == CNT_LAST)
                                                         : (r_dir_down && (r_cnt == '0)));

    // Period counter plus boundary loading of active duties and mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
            r_mode_act <= PWM_MODE_EDGE;
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= DUTY_RST;
        end else if (ena) begin
            if (w_bnd) begin
                r_cnt      <= '0;
                r_dir_down <= 1'b0;
                r_mode_act <= mode;
                for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty_sh[i];
            end else if (r_mode_act == PWM_MODE_EDGE) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!r_dir_down) begin
                // The top value is held for a second clock as the ramp turns.
                if (r_cnt == CNT_LAST) r_dir_down <= 1'b1;
                else                   r_cnt      <= r_cnt + 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ---- compare stage: outputs lag the counter by one clock ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_p1  <= '0;
            r_wrap_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) r_pwm_p1[i] <= ena && (r_cnt < r_duty_act[i]);
            r_wrap_p1 <= w_bnd;
        end
    end

    assign pwm_out     = r_pwm_p1;
    assign period_wrap = r_wrap_p1;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl (4 channels, PERIOD=10, DEB_DIV=4).
module tb_pwm_multi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       inc_btn = 1'b0;
    logic       dec_btn = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] ch_sel = 2'd0;
    logic [3:0] pwm_out;
    logic [7:0] duty_o;
    logic       period_wrap;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] ch;
        logic       inc;
        logic       dec;
        logic [7:0] exp_duty;
        logic [1:0] pwm_const;   // [1]=check output constant, [0]=its level
    } vec_t;

    vec_t tbl [21];

    pwm_multi_ctrl #(
        .NUM_CH(4), .CNT_W(8), .PERIOD(10), .STEP(1), .DEB_DIV(4), .DUTY_INIT(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .inc_btn     (inc_btn),
        .dec_btn     (dec_btn),
        .ch_sel      (ch_sel),
        .mode        (mode),
        .pwm_out     (pwm_out),
        .duty_o      (duty_o),
        .period_wrap (period_wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [1:0] ch, input logic i, input logic d);
        ch_sel  = ch;
        inc_btn = i;
        dec_btn = d;
        repeat (20) step();
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (14) step();
    endtask

    task automatic wait_wrap(input int lim, output int pos);
        pos = -1;
        for (int k = 1; k <= lim; k++) begin
            step();
            if (period_wrap) begin
                pos = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pos, h0, h2, h0b, h2b, t6, bad, c;
        logic [3:0] exp_v;

        tbl[0]  = '{2'd0, 1'b1, 1'b0, 8'd6,  2'b00};
        tbl[1]  = '{2'd0, 1'b1, 1'b0, 8'd7,  2'b00};
        tbl[2]  = '{2'd0, 1'b1, 1'b0, 8'd8,  2'b00};
        tbl[3]  = '{2'd0, 1'b1, 1'b0, 8'd9,  2'b00};
        tbl[4]  = '{2'd0, 1'b1, 1'b0, 8'd10, 2'b00};
        tbl[5]  = '{2'd0, 1'b1, 1'b0, 8'd10, 2'b00};
        tbl[6]  = '{2'd0, 1'b1, 1'b0, 8'd10, 2'b11};
        tbl[7]  = '{2'd0, 1'b0, 1'b1, 8'd9,  2'b00};
        tbl[8]  = '{2'd0, 1'b0, 1'b1, 8'd8,  2'b00};
        tbl[9]  = '{2'd0, 1'b0, 1'b1, 8'd7,  2'b00};
        tbl[10] = '{2'd0, 1'b0, 1'b1, 8'd6,  2'b00};
        tbl[11] = '{2'd0, 1'b0, 1'b1, 8'd5,  2'b00};
        tbl[12] = '{2'd0, 1'b0, 1'b1, 8'd4,  2'b00};
        tbl[13] = '{2'd0, 1'b0, 1'b1, 8'd3,  2'b00};
        tbl[14] = '{2'd0, 1'b0, 1'b1, 8'd2,  2'b00};
        tbl[15] = '{2'd0, 1'b0, 1'b1, 8'd1,  2'b00};
        tbl[16] = '{2'd0, 1'b0, 1'b1, 8'd0,  2'b00};
        tbl[17] = '{2'd0, 1'b0, 1'b1, 8'd0,  2'b00};
        tbl[18] = '{2'd0, 1'b0, 1'b1, 8'd0,  2'b10};
        tbl[19] = '{2'd3, 1'b0, 1'b1, 8'd4,  2'b00};
        tbl[20] = '{2'd1, 1'b1, 1'b1, 8'd5,  2'b00};

        // Test 1: reset state and default 5/10 edge-aligned waveform
        step();
        check("rst_pwm", pwm_out, 0);
        check("rst_wrap", period_wrap, 0);
        check("rst_duty", duty_o, 5);
        repeat (2) step();
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_v = (((k - 1) % 10) < 5) ? 4'hF : 4'h0;
            check($sformatf("t1_pwm_k%0d", k), pwm_out, exp_v);
            check($sformatf("t1_wrap_k%0d", k), period_wrap, (k % 10) == 0);
        end

        // Test 2: held inc on ch2 gives one event, applied at next boundary
        wait_wrap(15, pos);
        check("t2_sync_wrap", pos > 0, 1);
        ch_sel = 2'd2;
        inc_btn = 1'b1;
        h0 = 0; h2 = 0; h0b = 0; h2b = 0; t6 = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (t6 < 0 && duty_o == 8'd6) t6 = k;
            if (k <= 10) begin
                h0 += int'(pwm_out[0]);
                h2 += int'(pwm_out[2]);
            end else begin
                h0b += int'(pwm_out[0]);
                h2b += int'(pwm_out[2]);
            end
            if (k == 10 || k == 20) check($sformatf("t2_wrap_k%0d", k), period_wrap, 1);
        end
        inc_btn = 1'b0;
        check("t2_latency_ok", (t6 >= 1 && t6 <= 11), 1);
        check("t2_ch2_old_period", h2, 5);
        check("t2_ch2_new_period", h2b, 6);
        check("t2_ch0_period_a", h0, 5);
        check("t2_ch0_period_b", h0b, 5);
        repeat (14) step();
        check("t2_single_event", duty_o, 6);

        // Test 3: table of presses (saturation, dec, simultaneous inc+dec)
        for (int i = 0; i < 21; i++) begin
            press(tbl[i].ch, tbl[i].inc, tbl[i].dec);
            check($sformatf("vec%0d_duty", i), duty_o, tbl[i].exp_duty);
            if (tbl[i].pwm_const[1]) begin
                bad = 0;
                for (int k = 0; k < 20; k++) begin
                    step();
                    if (pwm_out[tbl[i].ch] !== tbl[i].pwm_const[0]) bad++;
                end
                check($sformatf("vec%0d_pwm_const_bad", i), bad, 0);
            end
        end
        ch_sel = 2'd2;
        #1;
        check("t3_ch2_untouched", duty_o, 6);

        // Test 4: short pulse away from a sample tick, then inc+dec together
        do_reset();
        ch_sel = 2'd0;
        while ((cyc % 4) != 3) step();
        inc_btn = 1'b1;
        step();
        inc_btn = 1'b0;
        repeat (20) step();
        check("t4_short_pulse", duty_o, 5);
        press(2'd0, 1'b1, 1'b1);
        check("t4_inc_dec_same", duty_o, 5);

        // Test 5: center-aligned with duty 4 on ch1
        press(2'd1, 1'b0, 1'b1);
        check("t5_ch1_duty", duty_o, 4);
        mode = 1'b1;
        wait_wrap(15, pos);
        check("t5_switch_wrap", pos > 0, 1);
        for (int k = 1; k <= 40; k++) begin
            int j;
            step();
            j = ((k - 1) % 20) + 1;
            c = (j <= 10) ? (j - 1) : (20 - j);
            exp_v = {c < 5, c < 5, c < 4, c < 5};
            check($sformatf("t5_pwm_k%0d", k), pwm_out, exp_v);
            check($sformatf("t5_wrap_k%0d", k), period_wrap, j == 20);
        end

        // Test 6: async reset mid-period, restart, then ena freeze
        press(2'd2, 1'b1, 1'b0);
        press(2'd2, 1'b1, 1'b0);
        check("t6_duty7", duty_o, 7);
        pos = -1;
        for (int k = 1; k <= 20; k++) begin
            if (pwm_out != 4'h0) begin
                pos = k;
                break;
            end
            step();
        end
        check("t6_pwm_active", pos > 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_pwm", pwm_out, 0);
        check("t6_async_wrap", period_wrap, 0);
        for (int ch = 0; ch < 4; ch++) begin
            ch_sel = 2'(ch);
            #1;
            check($sformatf("t6_rst_duty_ch%0d", ch), duty_o, 5);
        end
        mode = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_v = (((k - 1) % 10) < 5) ? 4'hF : 4'h0;
            check($sformatf("t6_restart_pwm_k%0d", k), pwm_out, exp_v);
            check($sformatf("t6_restart_wrap_k%0d", k), period_wrap, k == 10);
        end
        ena = 1'b0;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (pwm_out !== 4'h0 || period_wrap !== 1'b0) bad++;
        end
        check("t6_ena_off_bad", bad, 0);
        ena = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_v = (k <= 2 || k >= 8) ? 4'hF : 4'h0;
            check($sformatf("t6_resume_pwm_k%0d", k), pwm_out, exp_v);
            check($sformatf("t6_resume_wrap_k%0d", k), period_wrap, k == 7);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
